instr_issue_unit: RTL

- Upstream feeder for the register-file processor core.
- Buffers 34-bit instructions from a loader in a small FIFO.
- Presents one instruction at a time on the core's instruct/instruct_sig handshake, then waits for the core's completion pulse before issuing the next.
- Includes a watchdog, so a stalled or unrecognised instruction cannot hang the issue stream.

---
 rtl/instr_issue_unit_pkg.sv | 19 +
 rtl/instr_fifo.sv | 69 ++++++
 rtl/instr_issue_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit and its FIFO.
//   INSTR_W     : instruction word width (passed through, never decoded)
//   DEPTH_DEF   : default FIFO depth
//   TIMEOUT_DEF : default watchdog limit in EXEC cycles
//   state_e     : issue FSM states
package instr_issue_unit_pkg;

    localparam int unsigned INSTR_W     = 34;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        EXEC,
        RETIRE
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored while full
//   pop      : discard head entry; ignored while empty
//   dout     : current head entry (valid when !empty)
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
module instr_fifo
    import instr_issue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: buffers loader words and issues them one at a time
// to the core over the instruct/instruct_sig handshake, with a watchdog.
//   clk, rst     : clock, synchronous active-high reset
//   load_valid   : loader offers load_instr
//   load_instr   : instruction word from the loader
//   load_ready   : FIFO not full; push on load_valid && load_ready
//   instruct     : registered instruction to the core
//   instruct_sig : registered, 0 = arm/idle, 1 = execute
//   done_sig     : one-cycle completion pulse from the core (EXEC only)
//   busy         : FSM in ARM, EXEC or RETIRE
//   timeout_err  : sticky watchdog flag, cleared only by rst
//   issued_count : retired instruction count, wraps at 255
module instr_issue_unit
    import instr_issue_unit_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned ARM_CYCLES = 1,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               load_ready,
    output logic [INSTR_W-1:0] instruct,
    output logic               instruct_sig,
    input  logic               done_sig,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         issued_count
);

    localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               sig_q, sig_d;
    logic [ARM_W-1:0]   arm_q, arm_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               fifo_pop;
    logic [INSTR_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (load_valid && load_ready),
        .din   (load_instr),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        arm_d    = arm_q;
        wd_d     = wd_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    instr_d = fifo_head;
                    arm_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (arm_q == ARM_W'(ARM_CYCLES - 1)) begin
                    wd_d    = '0;
                    state_d = EXEC;
                end else begin
                    arm_d = arm_q + 1'b1;
                end
            end
            EXEC: begin
                // done_sig wins over an expiring watchdog on the same cycle.
                if (done_sig) begin
                    state_d = RETIRE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RETIRE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RETIRE: begin
                fifo_pop = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered strobe tracks the state being entered.
        sig_d = (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            sig_q   <= 1'b0;
            arm_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            sig_q   <= sig_d;
            arm_q   <= arm_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_ready   = !fifo_full;
    assign instruct     = instr_q;
    assign instruct_sig = sig_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = err_q;
    assign issued_count = cnt_q;

endmodule
